am_demod: RTL and testbench

Sampled-domain AM demodulator: the receive-side counterpart of the AM modulator device, recovering the modulation envelope from a carrier-plus-sidebands sample stream. Carrier half-cycles are tracked with a hysteresis (Schmitt/relay-style) sign detector. Each half-cycle's rectified peak is captured, and the peaks are smoothed by a 2^AVG_LOG2-tap boxcar. It sits after the ADC/sample source in mixed-signal co-simulation benches and feeds envelope consumers.

---
 rtl/am_demod_pkg.sv | 23 ++
 rtl/am_boxcar.sv | 60 ++++++
 rtl/am_demod.sv | 171 +++++++++++++++++
 tb/tb_am_demod.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/am_demod_pkg.sv
// Shared types and width helpers for the AM envelope demodulator.
// Imported by the top-level detector and the boxcar smoother.
package am_demod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POS  = 2'd1,
    ST_NEG  = 2'd2
  } state_e;

  localparam int LOCK_COUNT = 3;
  localparam int LOCK_W     = 2;

  // Half-period counter must be able to hold MAX_HALF itself.
  function automatic int cnt_width(input int max_half);
    return $clog2(max_half + 1);
  endfunction

  function automatic int sum_width(input int data_w, input int avg_log2);
    return data_w + avg_log2;
  endfunction

endpackage

// File: rtl/am_boxcar.sv
// Running-sum boxcar over the last 2^AVG_LOG2 half-cycle peaks.
// Output and valid are registered: one pulse per accepted push, value held between pushes.
module am_boxcar
  import am_demod_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = sum_width(DATA_W, AVG_LOG2);

  logic [DATA_W-1:0]   ring_r [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_r;
  logic [SUM_W-1:0]    sum_r;
  logic [SUM_W-1:0]    sum_next_s;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;

  // Next running sum: add the new peak, retire the one it overwrites.
  always_comb begin
    sum_next_s = sum_r + SUM_W'(in_data) - SUM_W'(ring_r[wr_ptr_r]);
  end

  // Ring, pointer, sum and registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_r[i] <= '0;
      end
      wr_ptr_r    <= '0;
      sum_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        ring_r[wr_ptr_r] <= in_data;
        wr_ptr_r         <= wr_ptr_r + AVG_LOG2'(1);
        sum_r            <= sum_next_s;
        out_data_r       <= sum_next_s[SUM_W-1:AVG_LOG2];
      end else begin
        wr_ptr_r   <= wr_ptr_r;
        sum_r      <= sum_r;
        out_data_r <= out_data_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: rtl/am_demod.sv
// AM envelope demodulator: hysteresis half-cycle tracker, per-half peak capture,
// carrier lock qualification, and a boxcar-smoothed envelope output.
module am_demod
  import am_demod_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int HYST     = 256,
  parameter int AVG_LOG2 = 2,
  parameter int MIN_HALF = 2,
  parameter int MAX_HALF = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic        [DATA_W-1:0] out_env,
  output logic                     carrier_lock
);

  localparam int CNT_W = cnt_width(MAX_HALF);

  localparam logic signed [DATA_W-1:0] hyst_pos_c = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] hyst_neg_c = DATA_W'(-HYST);
  localparam logic [DATA_W-1:0] abs_max_c = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] neg_min_c = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  cnt_one_c  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  min_half_c = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0]  max_half_c = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0]  tmo_cnt_c  = CNT_W'(MAX_HALF - 1);
  localparam logic [LOCK_W-1:0] lock_max_c = LOCK_W'(LOCK_COUNT);

  // The most-negative code has no positive twin; clamp it to full scale.
  function automatic logic [DATA_W-1:0] rectify(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    if (x == neg_min_c) begin
      r = abs_max_c;
    end else if (x[DATA_W-1]) begin
      r = $unsigned(-x);
    end else begin
      r = $unsigned(x);
    end
    return r;
  endfunction

  state_e            state_r;
  logic [DATA_W-1:0] peak_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [LOCK_W-1:0] lock_cnt_r;
  logic              carrier_lock_r;

  logic [DATA_W-1:0] abs_s;
  logic [DATA_W-1:0] peak_max_s;
  logic              above_s;
  logic              below_s;
  logic              cross_s;
  logic              push_s;
  logic              timeout_s;
  logic              in_range_s;
  logic [LOCK_W-1:0] lock_next_s;

  // Sample classification and crossing/timeout decode for the current sample.
  always_comb begin
    abs_s      = rectify(in_data);
    above_s    = (in_data > hyst_pos_c);
    below_s    = (in_data < hyst_neg_c);
    peak_max_s = (abs_s > peak_r) ? abs_s : peak_r;
    cross_s    = 1'b0;
    case (state_r)
      ST_POS:  cross_s = below_s;
      ST_NEG:  cross_s = above_s;
      ST_IDLE: cross_s = 1'b0;
      default: cross_s = 1'b0;
    endcase
    push_s     = in_valid & cross_s;
    // A crossing sample always wins over a timeout on the same sample.
    timeout_s  = in_valid & ~cross_s & (state_r != ST_IDLE) & (cnt_r == tmo_cnt_c);
    in_range_s = (cnt_r >= min_half_c) && (cnt_r <= max_half_c);
  end

  // Lock counter next value: qualify each completed half-period.
  always_comb begin
    lock_next_s = lock_cnt_r;
    if (push_s) begin
      if (!in_range_s) begin
        lock_next_s = '0;
      end else if (lock_cnt_r != lock_max_c) begin
        lock_next_s = lock_cnt_r + LOCK_W'(1);
      end else begin
        lock_next_s = lock_cnt_r;
      end
    end else if (timeout_s) begin
      lock_next_s = '0;
    end else begin
      lock_next_s = lock_cnt_r;
    end
  end

  // Hysteresis half-cycle tracker with peak and half-period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      peak_r  <= '0;
      cnt_r   <= '0;
    end else if (in_valid) begin
      case (state_r)
        ST_IDLE: begin
          // Entering from IDLE only aligns phase; the partial half is not emitted.
          if (above_s) begin
            state_r <= ST_POS;
            peak_r  <= abs_s;
            cnt_r   <= cnt_one_c;
          end else if (below_s) begin
            state_r <= ST_NEG;
            peak_r  <= abs_s;
            cnt_r   <= cnt_one_c;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_POS, ST_NEG: begin
          if (cross_s) begin
            state_r <= (state_r == ST_POS) ? ST_NEG : ST_POS;
            peak_r  <= abs_s;
            cnt_r   <= cnt_one_c;
          end else if (timeout_s) begin
            state_r <= ST_IDLE;
            peak_r  <= '0;
            cnt_r   <= '0;
          end else begin
            peak_r  <= peak_max_s;
            cnt_r   <= cnt_r + cnt_one_c;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          peak_r  <= '0;
          cnt_r   <= '0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Lock state register; the output is registered alongside the envelope pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_r     <= '0;
      carrier_lock_r <= 1'b0;
    end else begin
      lock_cnt_r     <= lock_next_s;
      carrier_lock_r <= (lock_next_s == lock_max_c);
    end
  end

  am_boxcar #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_boxcar (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push_s),
    .in_data   (peak_r),
    .out_valid (out_valid),
    .out_data  (out_env)
  );

  assign carrier_lock = carrier_lock_r;

endmodule

// File: tb/tb_am_demod.sv
// Self-checking bench for am_demod: table-driven square-carrier vectors,
// directed corner sequences, and randomized stimulus against a queue-based model.
module tb_am_demod;

  localparam int HYST     = 256;
  localparam int MIN_HALF = 2;
  localparam int MAX_HALF = 1024;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic        [15:0] out_env;
  logic               carrier_lock;

  int tests;
  int fails;

  // Reference model state: phase (-1/0/+1), current half peak/length, lock streak, last 4 peaks.
  int m_mode, m_peak, m_cnt, m_lock, m_env;
  bit m_valid;
  int m_hist[$];

  am_demod dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_env      (out_env),
    .carrier_lock (carrier_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string nm, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endfunction

  task automatic model_step(input bit r, input bit v, input int d);
    int a, sum;
    bit hi, lo;
    m_valid = 1'b0;
    if (r) begin
      m_mode = 0; m_peak = 0; m_cnt = 0; m_lock = 0; m_env = 0;
      m_hist = '{0, 0, 0, 0};
    end else if (v) begin
      a  = (d == -32768) ? 32767 : ((d < 0) ? -d : d);
      hi = (d > HYST);
      lo = (d < -HYST);
      if (m_mode == 0) begin
        if (hi || lo) begin
          m_mode = hi ? 1 : -1; m_peak = a; m_cnt = 1;
        end
      end else if ((m_mode == 1 && lo) || (m_mode == -1 && hi)) begin
        m_hist.push_back(m_peak);
        void'(m_hist.pop_front());
        sum = 0;
        foreach (m_hist[i]) sum += m_hist[i];
        m_env   = sum / 4;
        m_valid = 1'b1;
        if (m_cnt >= MIN_HALF && m_cnt <= MAX_HALF) m_lock = (m_lock < 3) ? m_lock + 1 : 3;
        else m_lock = 0;
        m_mode = -m_mode; m_peak = a; m_cnt = 1;
      end else begin
        m_cnt++;
        if (a > m_peak) m_peak = a;
        if (m_cnt >= MAX_HALF) begin
          m_mode = 0; m_lock = 0; m_peak = 0; m_cnt = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input int d);
    rst = r; in_valid = v; in_data = d[15:0];
    @(posedge clk); #1;
    model_step(r, v, d);
    check("out_valid", int'(out_valid), int'(m_valid));
    check("out_env", int'(out_env), m_env);
    check("carrier_lock", int'(carrier_lock), int'(m_lock == 3));
  endtask

  task automatic run_sq(input int amp, input int halves,
                        output int first_idx, output int first_env, output int pulses);
    first_idx = -1; first_env = -1; pulses = 0;
    for (int h = 0; h < halves; h++) begin
      for (int s = 0; s < 4; s++) begin
        step(1'b0, 1'b1, (h % 2 == 0) ? amp : -amp);
        if (out_valid) begin
          if (first_idx < 0) begin
            first_idx = h * 4 + s;
            first_env = int'(out_env);
          end
          pulses++;
        end
      end
    end
  endtask

  typedef struct {
    bit v;
    int data;
    bit ev;
    int eenv;
    bit elock;
  } vec_t;

  vec_t tbl[44];
  int   pulse_env[10];

  initial begin
    int idx, env, npulse, amp, sgn, left, d, lock_fall;
    bit v, r;
    tests = 0; fails = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 16'sd0;
    m_hist = '{0, 0, 0, 0};

    pulse_env = '{250, 500, 750, 1000, 1000, 1000, 1250, 1500, 1750, 2000};
    for (int k = 0; k < 44; k++) begin
      amp          = (k < 24) ? 1000 : 2000;
      tbl[k].v     = 1'b1;
      tbl[k].data  = ((k / 4) % 2 == 0) ? amp : -amp;
      tbl[k].ev    = (k >= 4) && (k % 4 == 0);
      tbl[k].eenv  = (k < 4) ? 0 : pulse_env[k / 4 - 1];
      tbl[k].elock = (k >= 12);
    end

    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5000);
    check("reset_valid", int'(out_valid), 0);
    check("reset_env", int'(out_env), 0);
    check("reset_lock", int'(carrier_lock), 0);

    // Square carrier ramp, then amplitude step.
    for (int k = 0; k < 44; k++) begin
      step(1'b0, tbl[k].v, tbl[k].data);
      check("tbl_valid", int'(out_valid), int'(tbl[k].ev));
      check("tbl_env", int'(out_env), tbl[k].eenv);
      check("tbl_lock", int'(carrier_lock), int'(tbl[k].elock));
    end

    // Timeout: zeros for MAX_HALF samples while locked.
    npulse = 0; lock_fall = -1;
    for (int j = 0; j < MAX_HALF; j++) begin
      step(1'b0, 1'b1, 0);
      if (out_valid) npulse++;
      if (!carrier_lock && lock_fall < 0) lock_fall = j;
    end
    check("tmo_pulses", npulse, 0);
    check("tmo_lock_fall_idx", lock_fall, 1019);
    check("tmo_env_hold", int'(out_env), 2000);
    run_sq(1000, 3, idx, env, npulse);
    check("realign_idx", idx, 4);
    check("realign_env", env, 1750);

    // Reset coincident with a crossing sample.
    run_sq(1000, 8, idx, env, npulse);
    step(1'b1, 1'b1, 1000);
    check("rst_cross_valid", int'(out_valid), 0);
    check("rst_cross_env", int'(out_env), 0);
    check("rst_cross_lock", int'(carrier_lock), 0);
    run_sq(1000, 3, idx, env, npulse);
    check("post_rst_idx", idx, 4);
    check("post_rst_env", env, 250);

    // In-band chatter from IDLE produces nothing.
    step(1'b1, 1'b1, 0);
    npulse = 0;
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 1'b1, (j % 2 == 0) ? 200 : -200);
      if (out_valid) npulse++;
    end
    check("hyst_pulses", npulse, 0);
    run_sq(1000, 2, idx, env, npulse);
    check("hyst_then_idx", idx, 4);
    check("hyst_then_env", env, 250);

    // Most-negative sample saturates to full scale.
    step(1'b1, 1'b1, 0);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 1000);
    step(1'b0, 1'b1, -32768);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, -1000);
    step(1'b0, 1'b1, 1000);
    check("minneg_env", int'(out_env), 8441);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 32767);
    for (int h = 0; h < 4; h++) begin
      for (int s = 0; s < 4; s++) step(1'b0, 1'b1, (h % 2 == 0) ? -32768 : 32767);
    end
    step(1'b0, 1'b1, -32768);
    check("fullscale_env", int'(out_env), 32767);

    // Randomized carrier with varying amplitude, half length, gaps, noise and resets.
    sgn = 1; left = 0; amp = 1000;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        sgn  = -sgn;
        left = int'($urandom_range(1, 8));
        amp  = int'($urandom_range(300, 32767));
      end
      v = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 15))
        0:       d = int'($urandom_range(0, 512)) - 256;
        1:       d = (sgn < 0) ? -32768 : 32767;
        default: d = sgn * int'($urandom_range(257, amp));
      endcase
      if (v) left--;
      r = ($urandom_range(0, 599) == 0);
      step(r, v, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
